alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 212 +++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Multi-cycle ALU. Most operations finish one cycle after they are
//   accepted. MUL is an unsigned shift-add multiplier that takes W cycles.
//   The operands are latched when a request is accepted, so the caller may
//   change the inputs while busy is high.
//
// Ports
//   clk    rising-edge clock, the only clock
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   a      operand A
//   b      operand B, or the shift amount for SHL/SHR
//   ci     carry-in (ADD) or borrow-in (SUB)
//   opc    operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT,
//          6 SHL, 7 SHR, 8 MUL, 9-15 reserved (result 0)
//   w      registered result
//   co     carry-out or borrow-out
//   zero   registered result equals 0
//   neg    registered result MSB
//   ovf    signed overflow, or MUL high half nonzero
//   busy   operation in progress
//   done   one-cycle pulse when w and the flags update
// ---------------------------------------------------------------------------
module alu_multicycle #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  input  logic [3:0]   opc,
  output logic [W-1:0] w,
  output logic         co,
  output logic         zero,
  output logic         neg,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_ci;
  logic [3:0]      r_opc;
  logic [2*W-1:0]  r_mulAcc;
  logic [2*W-1:0]  r_mulMcand;
  logic [W-1:0]    r_mulMplier;
  logic [CW-1:0]   r_mulCount;

  logic [W-1:0]    r_w;
  logic            r_co;
  logic            r_zero;
  logic            r_neg;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;

  logic [W:0]      w_sum;
  logic [W:0]      w_diff;
  logic [SW-1:0]   w_shAmt;
  logic            w_shHigh;
  logic [W-1:0]    w_execW;
  logic            w_execCo;
  logic            w_execOvf;
  logic [2*W-1:0]  w_mulAccNext;

  assign w    = r_w;
  assign co   = r_co;
  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

  // Both arithmetic paths are one bit wider than the operands. The extra
  // top bit is the carry for ADD. For SUB it is the unsigned borrow,
  // because a - b - ci wraps below zero exactly when a < b + ci.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{W{1'b0}}, r_ci};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b} - {{W{1'b0}}, r_ci};

  // Shifts use only the low clog2(W) bits of b. Any set bit above those
  // means the shift is at least W, so the result is forced to zero.
  assign w_shAmt  = r_b[SW-1:0];
  assign w_shHigh = |r_b[W-1:SW];

  // Each MUL step adds the shifted multiplicand when the current
  // multiplier bit is set.
  assign w_mulAccNext = r_mulAcc + (r_mulMplier[0] ? r_mulMcand : {(2*W){1'b0}});

  // Single-cycle datapath, evaluated on the latched operands. Its result is
  // registered when the FSM leaves EXEC.
  always_comb begin
    w_execW   = '0;
    w_execCo  = 1'b0;
    w_execOvf = 1'b0;
    case (r_opc)
      4'd0: begin
        w_execW   = w_sum[W-1:0];
        w_execCo  = w_sum[W];
        w_execOvf = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      4'd1: begin
        w_execW   = w_diff[W-1:0];
        w_execCo  = w_diff[W];
        w_execOvf = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
      end
      4'd2: w_execW = r_a & r_b;
      4'd3: w_execW = r_a | r_b;
      4'd4: w_execW = r_a ^ r_b;
      4'd5: w_execW = ~r_a;
      4'd6: w_execW = w_shHigh ? '0 : (r_a << w_shAmt);
      4'd7: w_execW = w_shHigh ? '0 : (r_a >> w_shAmt);
      default: begin
        w_execW   = '0;
        w_execCo  = 1'b0;
        w_execOvf = 1'b0;
      end
    endcase
  end

  // Control FSM and all result registers. A request is latched in IDLE.
  // EXEC registers the result on the next edge. MUL runs W shift-add steps
  // and registers the result on the edge of the last step. Reset aborts any
  // operation without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_ci        <= 1'b0;
      r_opc       <= '0;
      r_mulAcc    <= '0;
      r_mulMcand  <= '0;
      r_mulMplier <= '0;
      r_mulCount  <= '0;
      r_w         <= '0;
      r_co        <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_ci   <= ci;
            r_opc  <= opc;
            r_busy <= 1'b1;
            if (opc == 4'd8) begin
              r_mulAcc    <= '0;
              r_mulMcand  <= {{W{1'b0}}, a};
              r_mulMplier <= b;
              r_mulCount  <= '0;
              r_state     <= MUL;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_w     <= w_execW;
          r_co    <= w_execCo;
          r_ovf   <= w_execOvf;
          r_zero  <= (w_execW == '0);
          r_neg   <= w_execW[W-1];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        MUL: begin
          r_mulAcc    <= w_mulAccNext;
          r_mulMcand  <= r_mulMcand << 1;
          r_mulMplier <= r_mulMplier >> 1;
          r_mulCount  <= r_mulCount + CW'(1);
          if (r_mulCount == CW'(W - 1)) begin
            r_w     <= w_mulAccNext[W-1:0];
            r_co    <= 1'b0;
            r_ovf   <= |w_mulAccNext[2*W-1:W];
            r_zero  <= (w_mulAccNext[W-1:0] == '0);
            r_neg   <= w_mulAccNext[W-1];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle at W=16 and W=8. It applies a
//   table of directed vectors, a few hand-written multi-cycle sequences
//   (busy-time start pulses, hold between done pulses, reset mid-MUL), and
//   a random sweep checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;

  logic        start16, ci16;
  logic [15:0] a16, b16;
  logic [3:0]  opc16;
  logic [15:0] w16;
  logic        co16, zero16, neg16, ovf16, busy16, done16;

  logic        start8, ci8;
  logic [7:0]  a8, b8;
  logic [3:0]  opc8;
  logic [7:0]  w8;
  logic        co8, zero8, neg8, ovf8, busy8, done8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] expW;
    logic        expCo;
    logic        expZ;
    logic        expN;
    logic        expV;
  } vec_t;

  vec_t vecs [14];

  // Free-running clock, period 10
  always #5 clk = ~clk;

  alu_multicycle #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .ci(ci16),
    .opc(opc16), .w(w16), .co(co16), .zero(zero16), .neg(neg16),
    .ovf(ovf16), .busy(busy16), .done(done16)
  );

  alu_multicycle #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .opc(opc8), .w(w8), .co(co8), .zero(zero8), .neg(neg8),
    .ovf(ovf8), .busy(busy8), .done(done8)
  );

  // One comparison: counts it and reports a failure on mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint toSigned(input longint v, input int width);
    return (v >= (longint'(1) << (width - 1))) ? v - (longint'(1) << width) : v;
  endfunction

  // Reference model worked from the operation definitions with plain
  // integer arithmetic on 64-bit values
  function automatic void refModel(input int width, input logic [3:0] opc,
                                   input longint a, input longint b, input longint ci,
                                   output longint w, output logic co, output logic z,
                                   output logic n, output logic v);
    longint mask = (longint'(1) << width) - 1;
    longint half = longint'(1) << (width - 1);
    longint s;
    longint sa = toSigned(a, width);
    longint sb = toSigned(b, width);
    w  = 0;
    co = 1'b0;
    v  = 1'b0;
    case (opc)
      4'd0: begin
        s  = a + b + ci;
        w  = s & mask;
        co = (s > mask);
        s  = sa + sb + ci;
        v  = (s >= half) || (s < -half);
      end
      4'd1: begin
        s  = a - b - ci;
        w  = s & mask;
        co = (a < b + ci);
        s  = sa - sb - ci;
        v  = (s >= half) || (s < -half);
      end
      4'd2: w = a & b;
      4'd3: w = a | b;
      4'd4: w = a ^ b;
      4'd5: w = (~a) & mask;
      4'd6: w = (b >= width) ? 0 : ((a << b) & mask);
      4'd7: w = (b >= width) ? 0 : (a >> b);
      4'd8: begin
        s = a * b;
        w = s & mask;
        v = ((s >> width) != 0);
      end
      default: w = 0;
    endcase
    z = (w == 0);
    n = ((w >> (width - 1)) & 1) != 0;
  endfunction

  task automatic driveInputs(input int width, input logic s, input logic [15:0] av,
                             input logic [15:0] bv, input logic civ, input logic [3:0] opv);
    if (width == 16) begin
      start16 = s; a16 = av; b16 = bv; ci16 = civ; opc16 = opv;
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0]; ci8 = civ; opc8 = opv;
    end
  endtask

  function automatic logic selDone(input int width);
    return (width == 16) ? done16 : done8;
  endfunction

  function automatic logic selBusy(input int width);
    return (width == 16) ? busy16 : busy8;
  endfunction

  // Issues one request, scrambles the operands after the accepting edge,
  // optionally pulses start with other operands while busy, and waits
  // (bounded) for done. Latency is counted in edges after the start edge.
  task automatic applyStimulus(input int width, input logic [15:0] av, input logic [15:0] bv,
                               input logic civ, input logic [3:0] opv, input bit disturb,
                               output int lat, output logic [15:0] wv, output logic [4:0] fl,
                               output logic busyFirst);
    @(negedge clk);
    driveInputs(width, 1'b1, av, bv, civ, opv);
    @(posedge clk);
    #1;
    driveInputs(width, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
    busyFirst = selBusy(width);
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (selDone(width) || lat >= 100) break;
      if (disturb)
        driveInputs(width, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
    end
    driveInputs(width, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
    if (width == 16) begin
      wv = w16;
      fl = {co16, zero16, neg16, ovf16, busy16};
    end else begin
      wv = {8'h00, w8};
      fl = {co8, zero8, neg8, ovf8, busy8};
    end
  endtask

  // Runs one request and compares latency, result, flags and busy
  task automatic runCheck(input string tag, input int width, input logic [15:0] av,
                          input logic [15:0] bv, input logic civ, input logic [3:0] opv,
                          input bit disturb, input logic [15:0] ew, input logic eco,
                          input logic ez, input logic en, input logic ev);
    int          lat;
    logic [15:0] wv;
    logic [4:0]  fl;
    logic        bf;
    applyStimulus(width, av, bv, civ, opv, disturb, lat, wv, fl, bf);
    checkOutput($sformatf("%s latency", tag), 64'(lat), 64'((opv == 4'd8) ? width : 1));
    checkOutput($sformatf("%s w", tag), 64'(wv), 64'(ew));
    checkOutput($sformatf("%s co", tag), 64'(fl[4]), 64'(eco));
    checkOutput($sformatf("%s zero", tag), 64'(fl[3]), 64'(ez));
    checkOutput($sformatf("%s neg", tag), 64'(fl[2]), 64'(en));
    checkOutput($sformatf("%s ovf", tag), 64'(fl[1]), 64'(ev));
    checkOutput($sformatf("%s busy at done", tag), 64'(fl[0]), 64'(0));
    checkOutput($sformatf("%s busy after start", tag), 64'(bf), 64'(1));
  endtask

  initial begin : main
    longint      mw;
    logic        mco, mz, mn, mv;
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    logic        rci;
    int          width;

    rst = 1'b1;
    driveInputs(16, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
    driveInputs(8, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0);

    // Directed vectors: {opc, a, b, ci, w, co, zero, neg, ovf}
    vecs[0]  = '{4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{4'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'd8, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{4'd6, 16'h0001, 16'h000F, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'd6, 16'h0001, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'd7, 16'h8000, 16'h0003, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'hC, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd2, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'd4, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd5, 16'h00FF, 16'h1234, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd8, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'd1, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs W16", 64'({w16, co16, zero16, neg16, ovf16, busy16, done16}), 64'(0));
    checkOutput("reset outputs W8", 64'({w8, co8, zero8, neg8, ovf8, busy8, done8}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 14; i++) begin
      runCheck($sformatf("vec%0d", i), 16, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].opc,
               vecs[i].opc == 4'd8, vecs[i].expW, vecs[i].expCo, vecs[i].expZ,
               vecs[i].expN, vecs[i].expV);
    end

    // Result and flags hold between done pulses
    repeat (3) @(negedge clk);
    checkOutput("hold w", 64'(w16), 64'(16'hFFFF));
    checkOutput("hold flags", 64'({co16, zero16, neg16, ovf16, done16}), 64'(5'b10100));

    // Reset during MUL iteration 5, then an immediate new MUL
    $display("[TB] reset during MUL");
    @(negedge clk);
    driveInputs(16, 1'b1, 16'h00FF, 16'h0101, 1'b0, 4'd8);
    @(posedge clk);
    #1;
    driveInputs(16, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid MUL busy/done", 64'({busy16, done16}), 64'(2'b10));
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort outputs", 64'({w16, co16, zero16, neg16, ovf16, busy16, done16}), 64'(0));
    rst = 1'b0;
    runCheck("post-reset MUL", 16, 16'h0003, 16'h0005, 1'b0, 4'd8, 1'b0,
             16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random sweep against the reference model at both widths
    $display("[TB] random sweep");
    for (int pass = 0; pass < 2; pass++) begin
      width = (pass == 0) ? 16 : 8;
      for (int i = 0; i < 1000; i++) begin
        rop = 4'($urandom_range(0, 8));
        ra  = 16'($urandom_range(0, (1 << width) - 1));
        rb  = (rop == 4'd6 || rop == 4'd7) ? 16'($urandom_range(0, 2 * width))
                                           : 16'($urandom_range(0, (1 << width) - 1));
        rci = 1'($urandom);
        refModel(width, rop, longint'(ra), longint'(rb), longint'(rci), mw, mco, mz, mn, mv);
        runCheck($sformatf("rnd W%0d #%0d opc%0d", width, i, rop), width, ra, rb, rci, rop,
                 ($urandom_range(0, 3) == 0), 16'(mw), mco, mz, mn, mv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
